// File: rtl/icache_pkg.sv
// icache_pkg: shared FSM state type, default cache geometry and the
// address-slice helpers used by the direct-mapped instruction cache.
package icache_pkg;

  // Default geometry: 4 words per line, 16 sets.
  localparam int OFFSET_W = 2;
  localparam int INDEX_W  = 4;
  localparam int TAG_W    = 32 - INDEX_W - OFFSET_W - 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Word offset inside the line: pc[ow+1:2].
  function automatic logic [31:0] pc_offset(input logic [31:0] pc, input int ow);
    return (pc >> 2) & ((32'd1 << ow) - 32'd1);
  endfunction

  // Set index: the iw bits above the word offset.
  function automatic logic [31:0] pc_index(input logic [31:0] pc, input int ow, input int iw);
    return (pc >> (2 + ow)) & ((32'd1 << iw) - 32'd1);
  endfunction

  // Tag: everything above the index.
  function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int ow, input int iw);
    return pc >> (2 + ow + iw);
  endfunction

  // Address of word 0 of the line holding pc.
  function automatic logic [31:0] line_base(input logic [31:0] pc, input int ow);
    return pc & ~((32'd1 << (2 + ow)) - 32'd1);
  endfunction

endpackage

// File: rtl/icache_dm_if.sv
// icache_dm_if: memory read port of the instruction cache.
// The cache drives the request through the master modport; the memory
// answers through the slave modport. A request is held until mem_ack_i.
interface icache_dm_if;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  modport master (
    output mem_req_o,
    output mem_addr_o,
    input  mem_ack_i,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_addr_o,
    output mem_ack_i,
    output mem_rdata_i
  );
endinterface

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: IDLE/REFILL/DONE sequencer of the instruction cache.
// Holds the miss PC, walks the line words 0..LINE_WORDS-1 over the memory
// handshake, reports each returned word for the data array and flags the
// last one so the top level can install tag and valid bit.
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int LINE_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [31:0]                   start_pc,
  input  logic                          flush,
  icache_dm_if.master                   mem,
  output logic                          in_idle,
  output logic                          in_refill,
  output logic                          in_done,
  output logic [31:0]                   miss_pc,
  output logic                          drop_flag,
  output logic                          wr_en,
  output logic [$clog2(LINE_WORDS)-1:0] wr_word,
  output logic [31:0]                   wr_data,
  output logic                          install
);

  localparam int OW = $clog2(LINE_WORDS);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_REFILL = REFILL;
  localparam logic [1:0] S_DONE   = DONE;

  logic [1:0]    state;
  logic [OW-1:0] cnt;
  logic          last_word;

  assign in_idle   = (state == S_IDLE);
  assign in_refill = (state == S_REFILL);
  assign in_done   = (state == S_DONE);
  assign last_word = (cnt == OW'(LINE_WORDS - 1));

  // Request and address come straight from flops, so they stay stable
  // while the memory is slow to answer.
  assign mem.mem_req_o  = in_refill;
  assign mem.mem_addr_o = line_base(miss_pc, OW) | (32'(cnt) << 2);

  assign wr_en   = in_refill && mem.mem_ack_i;
  assign wr_word = cnt;
  assign wr_data = mem.mem_rdata_i;
  assign install = wr_en && last_word;

  // Sequence IDLE -> REFILL (one word per ack) -> DONE -> IDLE; a flush
  // seen during the refill only marks the delivery for dropping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      drop_flag <= 1'b0;
      miss_pc   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_REFILL;
            miss_pc   <= start_pc;
            drop_flag <= 1'b0;
            cnt       <= '0;
          end
        end
        S_REFILL: begin
          if (flush) drop_flag <= 1'b1;
          if (mem.mem_ack_i) begin
            cnt <= cnt + 1'b1;
            if (last_word) state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped, read-only instruction cache between IF and the
// IF/ID register. Combinational lookup on if_pc_i, registered outputs;
// a miss refills the whole line through icache_refill_ctrl and then
// delivers the missed word.
// Optional feature macro ICACHE_PERF_EN adds hit/miss event counters.
module icache_dm
  import icache_pkg::*;
#(
  parameter int LINE_WORDS = 1 << OFFSET_W,
  parameter int SETS       = 1 << INDEX_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc_i,
  input  logic        if_req_i,
  input  logic        fc_flush_i,
  output logic [31:0] icache_inst_o,
  output logic [31:0] icache_pc_o,
  output logic        icache_valid_o,
  output logic        icache_miss_o,
`ifdef ICACHE_PERF_EN
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o,
`endif
  icache_dm_if.master mem
);

  localparam int OW = $clog2(LINE_WORDS);
  localparam int IW = $clog2(SETS);
  localparam int TW = 30 - OW - IW;

  logic [SETS-1:0] valid_q;
  logic [TW-1:0]   tag_q  [SETS];
  logic [31:0]     data_q [SETS][LINE_WORDS];

  logic [OW-1:0] lk_off;
  logic [IW-1:0] lk_idx;
  logic [TW-1:0] lk_tag;
  logic          lk_hit;
  logic          acc_hit;
  logic          acc_miss;

  logic          in_idle;
  logic          in_refill;
  logic          in_done;
  logic          drop_flag;
  logic          wr_en;
  logic          install;
  logic [31:0]   miss_pc;
  logic [31:0]   wr_data;
  logic [OW-1:0] wr_word;
  logic [OW-1:0] miss_off;
  logic [IW-1:0] miss_idx;
  logic [TW-1:0] miss_tag;

  assign lk_off = OW'(pc_offset(if_pc_i, OW));
  assign lk_idx = IW'(pc_index(if_pc_i, OW, IW));
  assign lk_tag = TW'(pc_tag(if_pc_i, OW, IW));

  assign miss_off = OW'(pc_offset(miss_pc, OW));
  assign miss_idx = IW'(pc_index(miss_pc, OW, IW));
  assign miss_tag = TW'(pc_tag(miss_pc, OW, IW));

  assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign acc_hit  = in_idle && if_req_i && lk_hit;
  assign acc_miss = in_idle && if_req_i && !lk_hit;

  assign icache_miss_o = in_refill;

  icache_refill_ctrl #(
    .LINE_WORDS (LINE_WORDS)
  ) u_refill (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (acc_miss),
    .start_pc  (if_pc_i),
    .flush     (fc_flush_i),
    .mem       (mem),
    .in_idle   (in_idle),
    .in_refill (in_refill),
    .in_done   (in_done),
    .miss_pc   (miss_pc),
    .drop_flag (drop_flag),
    .wr_en     (wr_en),
    .wr_word   (wr_word),
    .wr_data   (wr_data),
    .install   (install)
  );

  // Valid bits: cleared by reset, set only when the last refill word lands,
  // so a refill cut short by reset leaves its set invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else if (install) valid_q[miss_idx] <= 1'b1;
  end

  // Tag and data storage: written by the refill, guarded by valid_q.
  always_ff @(posedge clk) begin
    if (wr_en)   data_q[miss_idx][wr_word] <= wr_data;
    if (install) tag_q[miss_idx] <= miss_tag;
  end

  // Output register: hit word from IDLE, or the missed word from DONE;
  // a flush in the same cycle suppresses the valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icache_inst_o  <= '0;
      icache_pc_o    <= '0;
      icache_valid_o <= 1'b0;
    end else if (in_done) begin
      icache_valid_o <= !drop_flag && !fc_flush_i;
      icache_inst_o  <= data_q[miss_idx][miss_off];
      icache_pc_o    <= miss_pc;
    end else begin
      icache_valid_o <= acc_hit && !fc_flush_i;
      if (acc_hit) begin
        icache_inst_o <= data_q[lk_idx][lk_off];
        icache_pc_o   <= if_pc_i;
      end
    end
  end

`ifdef ICACHE_PERF_EN
  // Event counters: one count per accepted hit or miss, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (acc_hit)  hit_cnt_o  <= hit_cnt_o + 32'd1;
      if (acc_miss) miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: directed scenarios plus randomized fetch traffic for
// icache_dm, checked every cycle against a transaction-level cache model
// (read-only memory content is a pure function of the address).
module tb_icache_dm;
  import icache_pkg::*;

  localparam int LW   = 1 << OFFSET_W;
  localparam int SETS = 1 << INDEX_W;

  logic        clk;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        if_req;
  logic        fc_flush;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        valid;
  logic        miss;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  icache_dm_if mif ();

  icache_dm dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_pc_i        (if_pc),
    .if_req_i       (if_req),
    .fc_flush_i     (fc_flush),
    .icache_inst_o  (inst),
    .icache_pc_o    (pc),
    .icache_valid_o (valid),
    .icache_miss_o  (miss),
`ifdef ICACHE_PERF_EN
    .hit_cnt_o      (hit_cnt),
    .miss_cnt_o     (miss_cnt),
`endif
    .mem            (mif)
  );

  int checks = 0;
  int errors = 0;

  // model state
  bit          mv [SETS];
  logic [31:0] mt [SETS];
  bit          m_busy, m_done, m_drop;
  int          m_acks;
  logic [31:0] m_pc;
  logic        exp_valid, exp_miss;
  logic [31:0] exp_pc, exp_inst, exp_addr;

  // memory responder control
  int          fixed_delay = 0;
  bit          rand_mode   = 0;
  logic [31:0] ack_q [$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic int set_of(input logic [31:0] a);
    return int'((a >> (2 + OFFSET_W)) % SETS);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a >> (32 - TAG_W);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Reference model: advances on each edge from the inputs the bench drives.
  initial begin
    exp_valid = 0; exp_miss = 0; exp_pc = 0; exp_inst = 0; exp_addr = 0;
    m_busy = 0; m_done = 0; m_drop = 0; m_acks = 0; m_pc = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_busy = 0; m_done = 0; m_drop = 0; m_acks = 0;
        exp_valid = 0; exp_miss = 0;
        for (int s = 0; s < SETS; s++) mv[s] = 0;
      end else begin
        if (m_done) begin
          exp_valid = !m_drop && !fc_flush;
          exp_pc    = m_pc;
          exp_inst  = mem_word(m_pc);
          m_done    = 0;
        end else if (m_busy) begin
          exp_valid = 0;
          if (fc_flush) m_drop = 1;
          if (mif.mem_ack_i) begin
            m_acks++;
            if (m_acks == LW) begin
              m_busy = 0;
              m_done = 1;
              mv[set_of(m_pc)] = 1;
              mt[set_of(m_pc)] = tag_of(m_pc);
            end
          end
        end else begin
          exp_valid = 0;
          if (if_req) begin
            if (mv[set_of(if_pc)] && mt[set_of(if_pc)] == tag_of(if_pc)) begin
              exp_valid = !fc_flush;
              exp_pc    = if_pc;
              exp_inst  = mem_word(if_pc);
            end else begin
              m_busy = 1;
              m_acks = 0;
              m_pc   = if_pc;
              m_drop = 0;
            end
          end
        end
        exp_miss = m_busy;
        exp_addr = (m_pc & ~32'(LW * 4 - 1)) + 32'(m_acks * 4);
      end
    end
  end

  // Per-cycle comparison of DUT outputs with the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("valid", {31'd0, valid}, {31'd0, exp_valid});
        chk("miss", {31'd0, miss}, {31'd0, exp_miss});
        chk("mem_req", {31'd0, mif.mem_req_o}, {31'd0, exp_miss});
        if (exp_valid) begin
          chk("out_pc", pc, exp_pc);
          chk("out_inst", inst, exp_inst);
        end
        if (exp_miss) chk("mem_addr", mif.mem_addr_o, exp_addr);
      end
    end
  end

  // Memory responder: acks after a per-word delay, checks the request holds.
  initial begin
    int          wcnt;
    int          cur_delay;
    bit          have_wait;
    logic [31:0] wait_addr;
    wcnt = 0; cur_delay = 0; have_wait = 0; wait_addr = 0;
    mif.mem_ack_i   = 1'b0;
    mif.mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mif.mem_ack_i = 1'b0; wcnt = 0; have_wait = 0;
      end else if (!mif.mem_req_o) begin
        if (have_wait) chk("req_hold", {31'd0, mif.mem_req_o}, 32'd1);
        mif.mem_ack_i = 1'b0; wcnt = 0; have_wait = 0;
        cur_delay = rand_mode ? int'($urandom_range(0, 2)) : fixed_delay;
      end else begin
        if (have_wait) chk("addr_hold", mif.mem_addr_o, wait_addr);
        if (wcnt >= cur_delay) begin
          mif.mem_ack_i   = 1'b1;
          mif.mem_rdata_i = mem_word(mif.mem_addr_o);
          ack_q.push_back(mif.mem_addr_o);
          wcnt = 0; have_wait = 0;
          cur_delay = rand_mode ? int'($urandom_range(0, 2)) : fixed_delay;
        end else begin
          mif.mem_ack_i = 1'b0;
          wcnt++;
          have_wait = 1;
          wait_addr = mif.mem_addr_o;
        end
      end
    end
  end

  // One request, then wait (bounded) for a valid output.
  task automatic fetch_wait(input logic [31:0] a, output int lat,
                            output logic [31:0] got_pc, output logic [31:0] got_inst);
    @(negedge clk);
    if_req = 1'b1;
    if_pc  = a;
    lat = -1; got_pc = 'x; got_inst = 'x;
    for (int n = 1; n <= 64; n++) begin
      @(negedge clk);
      if (n == 1) if_req = 1'b0;
      if (valid) begin
        lat = n; got_pc = pc; got_inst = inst;
        break;
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_inst"}, inst, 32'd0);
    chk({tag, "_pc"}, pc, 32'd0);
    chk({tag, "_valid"}, {31'd0, valid}, 32'd0);
    chk({tag, "_miss"}, {31'd0, miss}, 32'd0);
    chk({tag, "_req"}, {31'd0, mif.mem_req_o}, 32'd0);
    chk({tag, "_addr"}, mif.mem_addr_o, 32'd0);
  endtask

  initial begin
    int          lat;
    logic [31:0] gp, gi;
    bit          seen;

    rst_n = 1'b0; if_req = 1'b0; if_pc = '0; fc_flush = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Cold miss with an ack every cycle
    ack_q.delete();
    fetch_wait(32'h100, lat, gp, gi);
    chk("cold_lat", lat, 32'd6);
    chk("cold_pc", gp, 32'h100);
    chk("cold_inst", gi, 32'h254D_E778);
    chk("cold_nacks", ack_q.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < ack_q.size()) chk("cold_addr", ack_q[i], 32'h100 + 32'(i * 4));

    // Back-to-back hits in the freshly filled line
    @(negedge clk); if_req = 1'b1; if_pc = 32'h104;
    @(negedge clk);
    chk("hit0_v", {31'd0, valid}, 32'd1); chk("hit0_pc", pc, 32'h104);
    chk("hit0_inst", inst, 32'hA263_C1BC);
    if_pc = 32'h108;
    @(negedge clk);
    chk("hit1_v", {31'd0, valid}, 32'd1); chk("hit1_pc", pc, 32'h108);
    if_pc = 32'h10C;
    @(negedge clk);
    chk("hit2_v", {31'd0, valid}, 32'd1); chk("hit2_pc", pc, 32'h10C);
    chk("hit_noreq", {31'd0, mif.mem_req_o}, 32'd0);
    if_req = 1'b0;

    // Conflict in set 0
    fetch_wait(32'h000, lat, gp, gi);
    chk("conf0_lat", lat, 32'd6);
    fetch_wait(32'h100, lat, gp, gi);
    chk("conf1_lat", lat, 32'd6);
    fetch_wait(32'h000, lat, gp, gi);
    chk("conf2_lat", lat, 32'd6);
    chk("conf2_pc", gp, 32'h000);

    // Slow memory: three idle cycles before each ack
    fixed_delay = 3;
    fetch_wait(32'h240, lat, gp, gi);
    chk("slow_lat", lat, 32'd18);
    chk("slow_pc", gp, 32'h240);
    fixed_delay = 0;

    // Flush in the second refill cycle drops the delivery but installs the line
    @(negedge clk); if_req = 1'b1; if_pc = 32'h100;
    @(negedge clk); if_req = 1'b0;
    @(negedge clk); fc_flush = 1'b1;
    @(negedge clk); fc_flush = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (valid) seen = 1;
    end
    chk("flush_drop", {31'd0, seen}, 32'd0);
    fetch_wait(32'h100, lat, gp, gi);
    chk("flush_hit_lat", lat, 32'd1);
    chk("flush_hit_inst", gi, 32'h254D_E778);

    // Reset after two refill words
    @(negedge clk); if_req = 1'b1; if_pc = 32'h380;
    @(negedge clk); if_req = 1'b0;
    @(negedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge clk); rst_n = 1'b1;
    fetch_wait(32'h380, lat, gp, gi);
    chk("midrst_lat", lat, 32'd6);
    fetch_wait(32'h100, lat, gp, gi);
    chk("midrst_100_lat", lat, 32'd6);

    // Randomized traffic over 4 tags x 16 sets, random acks and flushes
    rand_mode = 1;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      rst_n    = (i != 800);
      if_req   = ($urandom_range(0, 9) < 7);
      if_pc    = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4)
               | (32'($urandom_range(0, 3)) << 2);
      fc_flush = ($urandom_range(0, 9) == 0);
    end
    @(negedge clk);
    rst_n = 1'b1; if_req = 1'b0; fc_flush = 1'b0;
    repeat (40) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_dm.md
# icache_dm

Direct-mapped, read-only instruction cache between the IF stage and the IF/ID register. Each cycle it looks up the PC presented by IF. On a hit it returns the instruction one cycle later. On a miss it raises a back-and-keep request to flow control, refills the whole line from memory through a req/ack handshake, then delivers the missed instruction.

## Interface
- LINE_WORDS, 4: 32-bit words per line (power of two, ≥2)
- SETS, 16: number of lines (power of two)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- if_pc_i  in  32  fetch PC from IF; word-aligned
- if_req_i  in  1  fetch request valid
- fc_flush_i  in  1  flow-control flush (jump taken); cancels the pending miss delivery
- icache_inst_o  out  32  fetched instruction
- icache_pc_o  out  32  PC of icache_inst_o
- icache_valid_o  out  1  icache_inst_o/icache_pc_o valid this cycle
- icache_miss_o  out  1  to fc; drives fc_bk_if while high
- mem_req_o  out  1  memory read request
- mem_addr_o  out  32  word address of the request
- mem_ack_i  in  1  read data valid; completes the current request
- mem_rdata_i  in  32  read data

## Operation
- Address split: offset = pc[log2(LINE_WORDS)+1:2], index = next log2(SETS) bits, tag = remaining upper bits. pc[1:0] is ignored.
- Storage: per set, a valid bit, a tag, and LINE_WORDS data words, all in flops. Lookup is combinational on if_pc_i; outputs are registered.
- FSM states:
  - IDLE: lookup when if_req_i=1. Hit: register the word and PC, valid=1 next cycle. Miss: latch the miss PC, clear drop_flag, go to REFILL, miss_o=1 next cycle.
  - REFILL: words are fetched in order 0..LINE_WORDS-1 from the line base (miss_pc with offset cleared). mem_req_o and mem_addr_o are held stable until mem_ack_i. Each ack writes mem_rdata_i into the data array and advances the word counter. The ack of the last word writes the tag, sets the valid bit, and moves to DONE.
  - DONE: for one cycle, deliver the missed word with icache_pc_o = miss PC and valid=1, unless drop_flag is set. miss_o is cleared and the FSM returns to IDLE.
- if_req_i is ignored outside IDLE. Requests with if_req_i=0 never hit or miss.
- fc_flush_i:
  - In REFILL: sets drop_flag. The refill always completes and the line is installed, but DONE delivers nothing.
  - In IDLE: suppresses the output registered on that cycle.
- A refill overwrites the target set unconditionally; there is no replacement choice.
- The counter is log2(LINE_WORDS) bits wide and wraps to 0 on completion.

## Timing
- Reset values: icache_inst_o=0, icache_pc_o=0, icache_valid_o=0, icache_miss_o=0, mem_req_o=0, mem_addr_o=0, all valid bits=0, state=IDLE, counter=0, drop_flag=0.
- Hit latency: 1 cycle, request at edge N, valid during N+1. Back-to-back hits give one result per cycle.
- Miss timing:
  - miss_o rises the cycle after the request and stays high through the last REFILL cycle.
  - mem_req_o rises in the same cycle as miss_o.
  - Each word costs ≥1 cycle: mem_ack_i may arrive in the first cycle mem_req_o is high. The address advances the cycle after the ack.
  - mem_req_o drops in DONE.
- Minimum miss penalty: LINE_WORDS+2 cycles from request to delivery.
- Reset mid-refill: immediate return to the reset state. The partially written line stays invalid.

## Configuration
- ICACHE_PERF_EN:
  - Defined: adds outputs hit_cnt_o[31:0] and miss_cnt_o[31:0]. Each increments once per accepted hit or miss in IDLE, wraps at 2^32, and resets to 0.
  - Undefined: the ports and counters are absent, with no other behavioural change.

## Structure
- Shared package `icache_pkg`:
  - FSM state enum (IDLE, REFILL, DONE).
  - Derived widths OFFSET_W, INDEX_W, TAG_W.
  - Address-slice helper functions.
- One sub-module, `icache_refill_ctrl`: the REFILL/DONE sequencer, word counter, and mem handshake. The lookup and storage arrays stay in the top level.

## Test plan
- Cold miss, defaults: request pc=0x100 with the mem model acking every cycle. Expect miss_o high, mem_addr_o=0x100, 0x104, 0x108, 0x10C, then valid with pc=0x100 and data=word0, 6 cycles after the request.
- Refill-then-hits: after that refill, request 0x104, 0x108, 0x10C on consecutive cycles. Expect 3 consecutive valid outputs at 1-cycle latency, and mem_req_o stays 0.
- Conflict: fill 0x000, then request 0x100 (same index, different tag) → miss. Then request 0x000 → miss again.
- Slow memory: ack delayed 3 cycles per word. mem_req_o/mem_addr_o must stay stable while waiting; delivery comes 18 cycles after the request.
- Flush during refill: assert fc_flush_i in the 2nd REFILL cycle. Expect no valid in DONE, and a later request to 0x100 hits.
- Reset after 2 words of refill: all outputs return to 0, and a re-request of the same PC misses again.
